aes_stim_gen: RTL and testbench
===============================

# aes_stim_gen

Synthesizable, parametrised stimulus sequencer for AES cores of 128/192/256-bit key width. Two LFSRs generate plaintext and key vectors, which are issued to a fixed-latency, non-stallable AES pipeline. The block tracks issued and retired vectors and optionally compresses DUT outputs into a signature. It replaces bench-only LFSR and clock-gating stimulus with one clocked block usable in simulation and on FPGA.

## Interface
- DATA_W, 128: plaintext/ciphertext width.
- KEY_W, 128: key width; legal values are 128, 192 and 256.
- LATENCY, 21: DUT cycles from input to output; must be ≥1.
- CNT_W, 32: width of the test counters.
- STATE_SEED, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF: plaintext LFSR seed (DATA_W bits, nonzero).
- KEY_SEED, {KEY_W/64{64'hCAFE_FEED_CAFE_FEED}}: key LFSR seed (KEY_W bits, nonzero).
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- num_tests  in  CNT_W  vectors per run; sampled on the accepted start.
- key_mode  in  1  0 = new key per vector; 1 = key held at KEY_SEED. Sampled on start.
- pause  in  1  suppresses issue; inserts a bubble.
- state_o  out  DATA_W  plaintext to the DUT.
- key_o  out  KEY_W  key to the DUT.
- in_valid  out  1  state_o/key_o form a vector this cycle.
- dut_out  in  DATA_W  DUT ciphertext.
- out_valid  out  1  dut_out is a result this cycle.
- busy  out  1  high in SEED, RUN and DRAIN.
- done  out  1  level; high in DONE.
- issued_cnt  out  CNT_W  vectors issued this run.
- retired_cnt  out  CNT_W  results retired this run.
- misr_sig  out  DATA_W  output signature; present only with the macro enabled.

## Operation
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE/DONE + start → SEED. start is ignored in any other state.
- SEED (1 cycle):
  - Load both LFSRs with their seeds.
  - Clear counters, the valid delay line and misr_sig.
  - Next state is RUN, or DONE if num_tests==0.
- RUN:
  - in_valid = !pause.
  - On every valid cycle: issued_cnt++ and the plaintext LFSR advances. The key LFSR advances only if key_mode==0.
  - On the issue cycle where issued_cnt becomes num_tests, next state is DRAIN.
- DRAIN:
  - No issue; in_valid=0.
  - Leave for DONE on the cycle after the out_valid that brings retired_cnt to num_tests.
- Valid tracking:
  - LATENCY-deep shift register of in_valid; out_valid is its last stage.
  - retired_cnt++ on each out_valid.
- LFSRs: Galois, shifting toward MSB. Tap sets:
  - 128: 128,126,101,99
  - 192: 192,190,178,177
  - 256: 256,254,251,246
- state_o and key_o are direct LFSR register outputs and hold their value while paused or idle.
- pause in SEED, DRAIN, IDLE or DONE has no effect.
- Counters do not wrap: issued_cnt ≤ num_tests holds by construction.
- Reset values, including reset mid-run:
  - State is IDLE.
  - in_valid, out_valid, busy and done are 0.
  - Counters are 0 and the delay line is cleared.
  - LFSRs hold their seeds; misr_sig is 0.

## Timing
- start accepted at cycle T → SEED at T+1 → first in_valid at T+2, carrying STATE_SEED and KEY_SEED.
- A vector issued at cycle t produces out_valid at t+LATENCY.
- With no pauses and N≥1:
  - Last issue is at T+1+N.
  - Last out_valid is at T+1+N+LATENCY.
  - done rises at T+2+N+LATENCY.
- Each pause cycle in RUN delays all subsequent events by one cycle.
- A start pulse in DONE begins a new run.

## Configuration
- AES_STIM_MISR_EN:
  - Defined: misr_sig is present. On each out_valid, misr_sig ← rotl(misr_sig,1) ^ dut_out. It is cleared in SEED and held otherwise.
  - Undefined: no misr_sig port and no signature logic; dut_out is unused.

## Structure
- Package aes_stim_pkg holds:
  - The FSM state enum.
  - Tap-mask constants for widths 128/192/256.
  - A function returning the tap mask for a given width.
- Sub-module lfsr_galois (parameters WIDTH, SEED; ports enable, load) is instantiated twice.

## Test plan
- num_tests=4, key_mode=0, no pause, LATENCY=21 → in_valid high T+2..T+5; out_valid high T+23..T+26; done at T+27; issued=retired=4.
- key_mode=1, num_tests=3 → key_o equals KEY_SEED on all three issued vectors; state_o advances each vector.
- pause held high at T+3..T+4, num_tests=3 → vectors issued at T+2, T+5, T+6; out_valid gaps mirror the issue gaps; state_o is stable during the pause.
- num_tests=0 → SEED at T+1, done at T+2; in_valid never rises.
- rst_n asserted in DRAIN with retired=2 of 4 → all outputs and counters are 0 next cycle; a new start reproduces the first state_o exactly.
- AES_STIM_MISR_EN with dut_out tied to 1 and num_tests=2 → misr_sig = rotl(1,1)^1 = 3.

Source files
------------

// File: rtl/aes_stim_pkg.sv
// -----------------------------------------------------------------------------
// aes_stim_pkg
// Shared definitions for the AES stimulus sequencer:
//   - state_e      : sequencer FSM states
//   - TAPS_128/192/256 : Galois feedback masks (polynomial terms below x^WIDTH)
//   - tap_mask()   : selects the feedback mask for a given LFSR width
// -----------------------------------------------------------------------------
package aes_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Each mask holds the lower polynomial terms; the x^WIDTH term is the bit
  // shifted out of the MSB, which selects whether the mask is applied.
  // x^128 + x^126 + x^101 + x^99 + 1
  localparam logic [255:0] TAPS_128 = (256'd1 << 8'd126) | (256'd1 << 8'd101) |
                                      (256'd1 << 8'd99)  | 256'd1;
  // x^192 + x^190 + x^178 + x^177 + 1
  localparam logic [255:0] TAPS_192 = (256'd1 << 8'd190) | (256'd1 << 8'd178) |
                                      (256'd1 << 8'd177) | 256'd1;
  // x^256 + x^254 + x^251 + x^246 + 1
  localparam logic [255:0] TAPS_256 = (256'd1 << 8'd254) | (256'd1 << 8'd251) |
                                      (256'd1 << 8'd246) | 256'd1;

  // Feedback mask for a supported LFSR width; unsupported widths get zero.
  function automatic logic [255:0] tap_mask(input int unsigned width);
    logic [255:0] mask;
    case (width)
      32'd128: mask = TAPS_128;
      32'd192: mask = TAPS_192;
      32'd256: mask = TAPS_256;
      default: mask = 256'd0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/aes_stim_lfsr_galois.sv
// -----------------------------------------------------------------------------
// lfsr_galois
// Galois LFSR shifting toward the MSB. When the MSB is set, the tap mask for
// WIDTH (from aes_stim_pkg::tap_mask) is XORed into the shifted value.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (register -> SEED)
//   load       : reload SEED (takes priority over enable)
//   enable     : advance one step
//   q          : current LFSR register value
// -----------------------------------------------------------------------------
module lfsr_galois
  import aes_stim_pkg::*;
#(
  parameter int unsigned       WIDTH = 128,
  parameter logic [WIDTH-1:0]  SEED  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(tap_mask(WIDTH));

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  assign w_next = {r_q[WIDTH-2:0], 1'b0} ^ (r_q[WIDTH-1] ? MASK : {WIDTH{1'b0}});
  assign q      = r_q;

  // LFSR register: seed on reset/load, step on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= SEED;
    end else if (load) begin
      r_q <= SEED;
    end else if (enable) begin
      r_q <= w_next;
    end else begin
      r_q <= r_q;
    end
  end

endmodule

// File: rtl/aes_stim_gen.sv
// -----------------------------------------------------------------------------
// aes_stim_gen
// Stimulus sequencer for a fixed-latency, non-stallable AES pipeline.
// Two Galois LFSRs produce plaintext and key vectors; a LATENCY-deep valid
// delay line predicts when results come back. FSM: IDLE-SEED-RUN-DRAIN-DONE.
// Optional feature macro: AES_STIM_MISR_EN adds misr_sig, a rotate-and-XOR
// signature of dut_out taken on every out_valid.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : one-cycle run request (accepted in IDLE/DONE)
//   num_tests    : vectors per run (sampled on accepted start)
//   key_mode     : 0 = fresh key per vector, 1 = key fixed at KEY_SEED
//   pause        : suppresses issue during RUN
//   state_o/key_o: plaintext/key to the DUT; in_valid qualifies them
//   dut_out      : DUT ciphertext; out_valid marks a result cycle
//   busy, done   : status (SEED/RUN/DRAIN, DONE)
//   issued_cnt, retired_cnt : per-run vector counts
//   misr_sig     : output signature (AES_STIM_MISR_EN only)
// -----------------------------------------------------------------------------
module aes_stim_gen
  import aes_stim_pkg::*;
#(
  parameter int unsigned          DATA_W     = 128,
  parameter int unsigned          KEY_W      = 128,
  parameter int unsigned          LATENCY    = 21,
  parameter int unsigned          CNT_W      = 32,
  parameter logic [DATA_W-1:0]    STATE_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF,
  parameter logic [KEY_W-1:0]     KEY_SEED   = {KEY_W/64{64'hCAFE_FEED_CAFE_FEED}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_tests,
  input  logic              key_mode,
  input  logic              pause,
  output logic [DATA_W-1:0] state_o,
  output logic [KEY_W-1:0]  key_o,
  output logic              in_valid,
  input  logic [DATA_W-1:0] dut_out,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [CNT_W-1:0]  retired_cnt
`ifdef AES_STIM_MISR_EN
  , output logic [DATA_W-1:0] misr_sig
`endif
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_num_tests;
  logic               r_key_mode;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_retired;
  logic [LATENCY-1:0] r_vdl;
  logic               r_busy;
  logic               r_done;

  logic               w_in_valid;
  logic               w_load;
  logic               w_issue_last;
  logic               w_retire_last;
  logic [LATENCY:0]   w_vdl_next;

  // Issue is decided in the same cycle as pause so a pause cycle is a bubble.
  assign w_in_valid    = (r_state == ST_RUN) && !pause;
  assign w_load        = (r_state == ST_SEED);
  assign w_issue_last  = w_in_valid && ((r_issued + CNT_W'(1)) == r_num_tests);
  assign w_retire_last = out_valid && ((r_retired + CNT_W'(1)) == r_num_tests);
  // Extra bit lets the shift work unchanged for LATENCY == 1.
  assign w_vdl_next    = {r_vdl, w_in_valid};

  assign in_valid    = w_in_valid;
  assign out_valid   = r_vdl[LATENCY-1];
  assign busy        = r_busy;
  assign done        = r_done;
  assign issued_cnt  = r_issued;
  assign retired_cnt = r_retired;

  lfsr_galois #(
    .WIDTH (DATA_W),
    .SEED  (STATE_SEED)
  ) u_state_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .enable (w_in_valid),
    .q      (state_o)
  );

  lfsr_galois #(
    .WIDTH (KEY_W),
    .SEED  (KEY_SEED)
  ) u_key_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .enable (w_in_valid && !r_key_mode),
    .q      (key_o)
  );

  // Sequencer FSM with registered busy/done status and run-parameter capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_num_tests <= {CNT_W{1'b0}};
      r_key_mode  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state     <= ST_SEED;
            r_num_tests <= num_tests;
            r_key_mode  <= key_mode;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        ST_SEED: begin
          if (r_num_tests == {CNT_W{1'b0}}) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_retire_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Issue/retire counters; cleared at the start of every run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued  <= {CNT_W{1'b0}};
      r_retired <= {CNT_W{1'b0}};
    end else if (w_load) begin
      r_issued  <= {CNT_W{1'b0}};
      r_retired <= {CNT_W{1'b0}};
    end else begin
      if (w_in_valid) begin
        r_issued <= r_issued + CNT_W'(1);
      end
      if (out_valid) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Valid delay line mirroring the DUT pipeline depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vdl <= {LATENCY{1'b0}};
    end else if (w_load) begin
      r_vdl <= {LATENCY{1'b0}};
    end else begin
      r_vdl <= w_vdl_next[LATENCY-1:0];
    end
  end

`ifdef AES_STIM_MISR_EN
  logic [DATA_W-1:0] r_misr;

  assign misr_sig = r_misr;

  // Signature: rotate left by one, then fold in the DUT result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misr <= {DATA_W{1'b0}};
    end else if (w_load) begin
      r_misr <= {DATA_W{1'b0}};
    end else if (out_valid) begin
      r_misr <= {r_misr[DATA_W-2:0], r_misr[DATA_W-1]} ^ dut_out;
    end else begin
      r_misr <= r_misr;
    end
  end
`else
  // Without the signature, dut_out has no consumer.
  logic w_unused_dut;
  assign w_unused_dut = ^dut_out;
`endif

endmodule

// File: tb/tb_aes_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_aes_stim_gen
// Directed self-checking bench for aes_stim_gen with default parameters
// (DATA_W=KEY_W=128, LATENCY=21, CNT_W=32). Cycle offsets are relative to the
// cycle T in which start is high.
// -----------------------------------------------------------------------------
module tb_aes_stim_gen;

  localparam logic [127:0] S_SEED = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] K_SEED = 128'hCAFE_FEED_CAFE_FEED_CAFE_FEED_CAFE_FEED;
  // x^126 + x^101 + x^99 + 1 written out as a hex mask
  localparam logic [127:0] M128   = 128'h4000_0028_0000_0000_0000_0000_0000_0001;
  // One hand-computed step from each seed
  localparam logic [127:0] S_ONE  = 128'hFD5B_7DF7_BD5B_7DDF_BD5B_7DDF_BD5B_7DDF;
  localparam logic [127:0] K_ONE  = 128'hD5FD_FDF3_95FD_FDDB_95FD_FDDB_95FD_FDDB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  num_tests;
  logic         key_mode;
  logic         pause;
  logic [127:0] state_o;
  logic [127:0] key_o;
  logic         in_valid;
  logic [127:0] dut_out;
  logic         out_valid;
  logic         busy;
  logic         done;
  logic [31:0]  issued_cnt;
  logic [31:0]  retired_cnt;
`ifdef AES_STIM_MISR_EN
  logic [127:0] misr_sig;
`endif

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_state;
  logic [127:0] exp_key;
  int           exp_iss;
  int           exp_ret;

  aes_stim_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_tests   (num_tests),
    .key_mode    (key_mode),
    .pause       (pause),
    .state_o     (state_o),
    .key_o       (key_o),
    .in_valid    (in_valid),
    .dut_out     (dut_out),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done),
    .issued_cnt  (issued_cnt),
    .retired_cnt (retired_cnt)
`ifdef AES_STIM_MISR_EN
    , .misr_sig  (misr_sig)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] nxt(input logic [127:0] v);
    return v[127] ? ({v[126:0], 1'b0} ^ M128) : {v[126:0], 1'b0};
  endfunction

  // Pulse start during cycle T; returns at the start of cycle T+1.
  task automatic start_run(input int n, input bit km);
    num_tests = 32'(n);
    key_mode  = km;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
  endtask

  // Walk cycles T+c0..T+c1 checking every output against the bench model.
  // ivm: expected in_valid per cycle offset; pm: pause per cycle offset.
  task automatic watch(input int c0, input int c1, input logic [63:0] ivm,
                       input logic [63:0] pm, input int done_c, input bit km);
    logic ov;
    for (int c = c0; c <= c1; c++) begin
      pause = pm[c];
      #1;
      if (c == 1) begin
        exp_state = S_SEED;
        exp_key   = K_SEED;
        exp_iss   = 0;
        exp_ret   = 0;
      end
      ov = (c >= 21) ? ivm[c-21] : 1'b0;
      chk($sformatf("in_valid@T+%0d", c), 256'(in_valid), 256'(ivm[c]));
      chk($sformatf("out_valid@T+%0d", c), 256'(out_valid), 256'(ov));
      chk($sformatf("done@T+%0d", c), 256'(done), 256'(c >= done_c));
      chk($sformatf("busy@T+%0d", c), 256'(busy), 256'(c < done_c));
      if (c >= 2) begin
        chk($sformatf("state_o@T+%0d", c), 256'(state_o), 256'(exp_state));
        chk($sformatf("key_o@T+%0d", c), 256'(key_o), 256'(exp_key));
        chk($sformatf("issued@T+%0d", c), 256'(issued_cnt), 256'(exp_iss));
        chk($sformatf("retired@T+%0d", c), 256'(retired_cnt), 256'(exp_ret));
        if (ivm[c]) begin
          exp_state = nxt(exp_state);
          if (!km) exp_key = nxt(exp_key);
          exp_iss++;
        end
        if (ov) exp_ret++;
      end
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    pause     = 1'b0;
    key_mode  = 1'b0;
    num_tests = 32'd0;
    dut_out   = 128'd1;
    exp_state = S_SEED;
    exp_key   = K_SEED;
    exp_iss   = 0;
    exp_ret   = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_valid", 256'(in_valid), 256'(1'b0));
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_busy", 256'(busy), 256'(1'b0));
    chk("rst_done", 256'(done), 256'(1'b0));
    chk("rst_issued", 256'(issued_cnt), 256'(32'd0));
    chk("rst_retired", 256'(retired_cnt), 256'(32'd0));
    chk("rst_state_o", 256'(state_o), 256'(S_SEED));
    chk("rst_key_o", 256'(key_o), 256'(K_SEED));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // num_tests=4, fresh key per vector, no pause
    start_run(4, 1'b0);
    watch(1, 2, 64'h3C, 64'h0, 27, 1'b0);
    chk("A_state_step1", 256'(state_o), 256'(S_ONE));
    chk("A_key_step1", 256'(key_o), 256'(K_ONE));
    watch(3, 28, 64'h3C, 64'h0, 27, 1'b0);
    chk("A_issued_final", 256'(issued_cnt), 256'(32'd4));
    chk("A_retired_final", 256'(retired_cnt), 256'(32'd4));

    // key_mode=1, num_tests=3 (start from DONE)
    start_run(3, 1'b1);
    watch(1, 27, 64'h1C, 64'h0, 26, 1'b1);
    chk("B_key_held", 256'(key_o), 256'(K_SEED));

    // pause at T+3..T+4, num_tests=3: issues at T+2, T+5, T+6
    start_run(3, 1'b0);
    watch(1, 29, 64'h64, 64'h18, 28, 1'b0);

    // num_tests=0: SEED then straight to DONE
    start_run(0, 1'b0);
    watch(1, 4, 64'h0, 64'h0, 2, 1'b0);

    // Reset during DRAIN with two of four retired
    start_run(4, 1'b0);
    watch(1, 24, 64'h3C, 64'h0, 27, 1'b0);
    chk("E_retired_pre", 256'(retired_cnt), 256'(32'd2));
    chk("E_busy_pre", 256'(busy), 256'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("E_rst_in_valid", 256'(in_valid), 256'(1'b0));
    chk("E_rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("E_rst_busy", 256'(busy), 256'(1'b0));
    chk("E_rst_done", 256'(done), 256'(1'b0));
    chk("E_rst_issued", 256'(issued_cnt), 256'(32'd0));
    chk("E_rst_retired", 256'(retired_cnt), 256'(32'd0));
    chk("E_rst_state_o", 256'(state_o), 256'(S_SEED));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_run(1, 1'b0);
    watch(1, 25, 64'h4, 64'h0, 24, 1'b0);
    chk("E_rerun_state_step1", 256'(state_o), 256'(S_ONE));

`ifdef AES_STIM_MISR_EN
    // dut_out tied to 1, two results: rotl(1,1)^1 = 3
    start_run(2, 1'b0);
    watch(1, 26, 64'hC, 64'h0, 25, 1'b0);
    chk("MISR_sig", 256'(misr_sig), 256'(128'd3));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
